// File: rtl/controle_jogo.sv
// controle_jogo: two-player reaction-game controller.
// Conditions the start/button inputs, times the random "go" delay, the
// reaction window and the result hold, arbitrates presses and keeps both
// scores. Every output is taken straight from a flop.
module controle_jogo #(
  parameter int unsigned ARM_CYCLES    = 50_000_000,
  parameter int unsigned RAND_EN       = 1,
  parameter int unsigned RAND_SHIFT    = 18,
  parameter int unsigned WINDOW_CYCLES = 100_000_000,
  parameter int unsigned HOLD_CYCLES   = 100_000_000,
  parameter int unsigned WIN_SCORE     = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       btn_p1,
  input  logic       btn_p2,
  output logic [0:1] premio_f,
  output logic [0:3] p1_f,
  output logic [0:3] p2_f,
  output logic [0:3] state_f
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0000,
    S_ARMED = 4'b0001,
    S_GO    = 4'b0010,
    S_PRIZE = 4'b0011,
    S_OVER  = 4'b0100
  } state_e;

  localparam logic [31:0] ARM_LOAD    = 32'(ARM_CYCLES - 1);
  localparam logic [31:0] WINDOW_LOAD = 32'(WINDOW_CYCLES - 1);
  localparam logic [31:0] HOLD_LOAD   = 32'(HOLD_CYCLES - 1);
  localparam logic [3:0]  WIN_VAL     = 4'(WIN_SCORE);

  // Input conditioning: bit 0 = start, bit 1 = btn_p1, bit 2 = btn_p2.
  logic [2:0] sync1_q, sync2_q, prev_q, pulse_q;
  logic       st_p, p1_p, p2_p;

  logic [7:0]  lfsr_q;
  logic        lfsr_fb_s;
  logic [31:0] delay_s;

  state_e      state_q, state_d;
  logic [31:0] tmr_q, tmr_d;
  logic [1:0]  premio_q, premio_d;
  logic [3:0]  p1_q, p1_d, p2_q, p2_d;

  assign st_p = pulse_q[0];
  assign p1_p = pulse_q[1];
  assign p2_p = pulse_q[2];

  // Two-flop synchronizer followed by a registered rising-edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
      prev_q  <= 3'b000;
      pulse_q <= 3'b000;
    end else begin
      sync1_q <= {btn_p2, btn_p1, start};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= sync2_q & ~prev_q;
    end
  end

  // Free-running 8-bit LFSR, x^8+x^6+x^5+x^4+1; the seed keeps it off zero.
  assign lfsr_fb_s = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_fb_s};
    end
  end

  // Delay loaded on every entry to ARMED: fixed part plus scaled random part.
  always_comb begin
    delay_s = ARM_LOAD;
    if (RAND_EN != 0) begin
      delay_s = ARM_LOAD + ({24'd0, lfsr_q} << RAND_SHIFT);
    end else begin
      delay_s = ARM_LOAD;
    end
  end

  // State, timer, result and score registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tmr_q    <= 32'd0;
      premio_q <= 2'b00;
      p1_q     <= 4'd0;
      p2_q     <= 4'd0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      premio_q <= premio_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
    end
  end

  // Round sequencing and press arbitration.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    premio_d = premio_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (st_p) begin
          p1_d     = 4'd0;
          p2_d     = 4'd0;
          premio_d = 2'b00;
          tmr_d    = delay_s;
          state_d  = S_ARMED;
        end else begin
          state_d = state_q;
        end
      end
      S_ARMED: begin
        // A false start wins over the delay expiring in the same cycle.
        if (p1_p || p2_p) begin
          case ({p1_p, p2_p})
            2'b10: begin
              premio_d = 2'b10;
              p2_d     = p2_q + 4'd1;
            end
            2'b01: begin
              premio_d = 2'b01;
              p1_d     = p1_q + 4'd1;
            end
            default: begin
              premio_d = 2'b11;
            end
          endcase
          tmr_d   = HOLD_LOAD;
          state_d = S_PRIZE;
        end else if (tmr_q == 32'd0) begin
          tmr_d   = WINDOW_LOAD;
          state_d = S_GO;
        end else begin
          tmr_d = tmr_q - 32'd1;
        end
      end
      S_GO: begin
        // A press in the window's final cycle still scores.
        if (p1_p || p2_p) begin
          case ({p1_p, p2_p})
            2'b10: begin
              premio_d = 2'b01;
              p1_d     = p1_q + 4'd1;
            end
            2'b01: begin
              premio_d = 2'b10;
              p2_d     = p2_q + 4'd1;
            end
            default: begin
              premio_d = 2'b11;
            end
          endcase
          tmr_d   = HOLD_LOAD;
          state_d = S_PRIZE;
        end else if (tmr_q == 32'd0) begin
          premio_d = 2'b00;
          tmr_d    = HOLD_LOAD;
          state_d  = S_PRIZE;
        end else begin
          tmr_d = tmr_q - 32'd1;
        end
      end
      S_PRIZE: begin
        if (tmr_q == 32'd0) begin
          if ((p1_q == WIN_VAL) || (p2_q == WIN_VAL)) begin
            state_d = S_OVER;
          end else begin
            tmr_d    = delay_s;
            premio_d = 2'b00;
            state_d  = S_ARMED;
          end
        end else begin
          tmr_d = tmr_q - 32'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign state_f  = state_q;
  assign premio_f = premio_q;
  assign p1_f     = p1_q;
  assign p2_f     = p2_q;

endmodule

// File: tb/tb_controle_jogo.sv
// Bench for controle_jogo: a scripted game checked against constant
// expectations, an asynchronous reset taken mid-GO, then random button
// activity compared every cycle with a phase/elapsed-time game model.
module tb_controle_jogo;

  localparam int ARM  = 4;
  localparam int WINC = 8;
  localparam int HOLD = 3;
  localparam int WSC  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       btn_p1 = 1'b0;
  logic       btn_p2 = 1'b0;
  logic [0:1] premio_f;
  logic [0:3] p1_f, p2_f, state_f;

  controle_jogo #(
    .ARM_CYCLES(ARM), .RAND_EN(0), .RAND_SHIFT(18),
    .WINDOW_CYCLES(WINC), .HOLD_CYCLES(HOLD), .WIN_SCORE(WSC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .btn_p1(btn_p1), .btn_p2(btn_p2),
    .premio_f(premio_f), .p1_f(p1_f), .p2_f(p2_f), .state_f(state_f)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       st, b1, b2;
    int         n;
    logic [3:0] s;
    logic [1:0] pr;
    logic [3:0] a, b;
  } vec_t;
  vec_t tbl[$];

  // Game model: phase (0 idle,1 armed,2 go,3 prize,4 over) and cycles spent in it.
  int m_ph, m_cnt, m_pr, m_s1, m_s2;
  bit h_st[5], h_b1[5], h_b2[5];

  task automatic add(input logic st, b1, b2, input int n, input logic [3:0] s,
                     input logic [1:0] pr, input logic [3:0] a, b);
    vec_t v;
    v.st = st; v.b1 = b1; v.b2 = b2; v.n = n; v.s = s; v.pr = pr; v.a = a; v.b = b;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [3:0] s, input logic [1:0] pr,
                     input logic [3:0] a, input logic [3:0] b);
    checks++;
    if ({state_f, premio_f, p1_f, p2_f} !== {s, pr, a, b}) begin
      errors++;
      $display("FAIL %s: got state=%b premio=%b p1=%0d p2=%0d, expected state=%b premio=%b p1=%0d p2=%0d",
               name, state_f, premio_f, p1_f, p2_f, s, pr, a, b);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_cnt = 0; m_pr = 0; m_s1 = 0; m_s2 = 0;
    for (int i = 0; i < 5; i++) begin
      h_st[i] = 1'b0; h_b1[i] = 1'b0; h_b2[i] = 1'b0;
    end
  endtask

  // An input level that rose between samples n-4 and n-3 acts at edge n.
  task automatic model_edge();
    bit sp, bp1, bp2;
    for (int i = 4; i > 0; i--) begin
      h_st[i] = h_st[i-1]; h_b1[i] = h_b1[i-1]; h_b2[i] = h_b2[i-1];
    end
    h_st[0] = start; h_b1[0] = btn_p1; h_b2[0] = btn_p2;
    sp  = h_st[3] & ~h_st[4];
    bp1 = h_b1[3] & ~h_b1[4];
    bp2 = h_b2[3] & ~h_b2[4];
    case (m_ph)
      0, 4: begin
        if (sp) begin
          m_s1 = 0; m_s2 = 0; m_pr = 0; m_ph = 1; m_cnt = 0;
        end
      end
      1: begin
        if (bp1 || bp2) begin
          if (bp1 && bp2) m_pr = 3;
          else if (bp1) begin m_pr = 2; m_s2++; end
          else begin m_pr = 1; m_s1++; end
          m_ph = 3; m_cnt = 0;
        end else if (m_cnt == ARM - 1) begin
          m_ph = 2; m_cnt = 0;
        end else m_cnt++;
      end
      2: begin
        if (bp1 || bp2) begin
          if (bp1 && bp2) m_pr = 3;
          else if (bp1) begin m_pr = 1; m_s1++; end
          else begin m_pr = 2; m_s2++; end
          m_ph = 3; m_cnt = 0;
        end else if (m_cnt == WINC - 1) begin
          m_pr = 0; m_ph = 3; m_cnt = 0;
        end else m_cnt++;
      end
      3: begin
        if (m_cnt == HOLD - 1) begin
          if (m_s1 == WSC || m_s2 == WSC) m_ph = 4;
          else begin m_ph = 1; m_pr = 0; end
          m_cnt = 0;
        end else m_cnt++;
      end
      default: m_ph = 0;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; btn_p1 = 1'b0; btn_p2 = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    add(0,0,0,20, 4'd0,2'b00,4'd0,4'd0);
    add(1,0,0,3,  4'd0,2'b00,4'd0,4'd0);
    add(0,0,0,1,  4'd1,2'b00,4'd0,4'd0);
    add(0,0,0,3,  4'd1,2'b00,4'd0,4'd0);
    add(0,0,0,1,  4'd2,2'b00,4'd0,4'd0);
    add(0,1,0,3,  4'd2,2'b00,4'd0,4'd0);
    add(0,1,0,1,  4'd3,2'b01,4'd1,4'd0);
    add(0,1,0,2,  4'd3,2'b01,4'd1,4'd0);
    add(0,0,0,1,  4'd1,2'b00,4'd1,4'd0);
    add(0,0,0,3,  4'd1,2'b00,4'd1,4'd0);
    add(0,0,0,1,  4'd2,2'b00,4'd1,4'd0);
    add(0,1,1,3,  4'd2,2'b00,4'd1,4'd0);
    add(0,1,1,1,  4'd3,2'b11,4'd1,4'd0);
    add(0,0,0,2,  4'd3,2'b11,4'd1,4'd0);
    add(0,0,0,1,  4'd1,2'b00,4'd1,4'd0);
    add(0,0,1,3,  4'd1,2'b00,4'd1,4'd0);
    add(0,0,1,1,  4'd3,2'b01,4'd2,4'd0);
    add(0,0,0,2,  4'd3,2'b01,4'd2,4'd0);
    add(0,0,0,1,  4'd4,2'b01,4'd2,4'd0);
    add(0,1,0,6,  4'd4,2'b01,4'd2,4'd0);
    add(0,0,0,3,  4'd4,2'b01,4'd2,4'd0);
    add(1,0,0,3,  4'd4,2'b01,4'd2,4'd0);
    add(0,0,0,1,  4'd1,2'b00,4'd0,4'd0);
    add(0,0,0,3,  4'd1,2'b00,4'd0,4'd0);
    add(0,0,0,1,  4'd2,2'b00,4'd0,4'd0);
    add(0,0,0,5,  4'd2,2'b00,4'd0,4'd0);
    add(0,1,0,2,  4'd2,2'b00,4'd0,4'd0);
    add(0,1,0,1,  4'd3,2'b00,4'd0,4'd0);
    add(0,1,0,2,  4'd3,2'b00,4'd0,4'd0);
    add(0,1,0,1,  4'd1,2'b00,4'd0,4'd0);
    add(0,1,0,3,  4'd1,2'b00,4'd0,4'd0);
    add(0,1,0,1,  4'd2,2'b00,4'd0,4'd0);
    add(0,1,1,3,  4'd2,2'b00,4'd0,4'd0);
    add(0,1,1,1,  4'd3,2'b10,4'd0,4'd1);
    add(0,0,0,2,  4'd3,2'b10,4'd0,4'd1);
    add(0,0,0,1,  4'd1,2'b00,4'd0,4'd1);
    add(0,0,0,3,  4'd1,2'b00,4'd0,4'd1);
    add(0,0,0,1,  4'd2,2'b00,4'd0,4'd1);
    add(0,0,0,4,  4'd2,2'b00,4'd0,4'd1);
    add(0,0,1,3,  4'd2,2'b00,4'd0,4'd1);
    add(0,0,1,1,  4'd3,2'b10,4'd0,4'd2);
    add(0,0,0,2,  4'd3,2'b10,4'd0,4'd2);
    add(0,0,0,1,  4'd4,2'b10,4'd0,4'd2);

    // Reset state, then the scripted game.
    do_reset();
    #1 chk("reset", 4'd0, 2'b00, 4'd0, 4'd0);
    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].st; btn_p1 = tbl[i].b1; btn_p2 = tbl[i].b2;
      repeat (tbl[i].n) tick();
      chk($sformatf("vec%0d", i), tbl[i].s, tbl[i].pr, tbl[i].a, tbl[i].b);
    end

    // New game from OVER, then asynchronous reset in the middle of GO.
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    tick();
    chk("restart_armed", 4'd1, 2'b00, 4'd0, 4'd0);
    repeat (4) tick();
    chk("restart_go", 4'd2, 2'b00, 4'd0, 4'd0);
    #3 rst_n = 1'b0;
    #1 chk("async_reset_mid_go", 4'd0, 2'b00, 4'd0, 4'd0);

    // Random activity against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(15) == 0) start = ~start;
      if ($urandom_range(5) == 0) btn_p1 = ~btn_p1;
      if ($urandom_range(5) == 0) btn_p2 = ~btn_p2;
      tick();
      chk($sformatf("rand%0d", c), 4'(m_ph), 2'(m_pr), 4'(m_s1), 4'(m_s2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
